// File: rtl/tlc_mon_pkg.sv
// Shared types and constants for the traffic-light conflict monitor.
// The optional dark-lamp check is enabled with TLC_MON_DARK_CHECK_EN.
package tlc_mon_pkg;

    typedef enum logic [2:0] {
        COL_DARK  = 3'd0,
        COL_G     = 3'd1,
        COL_Y     = 3'd2,
        COL_R     = 3'd3,
        COL_MULTI = 3'd4
    } colour_t;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FLASH   = 2'd2,
        ST_RECOVER = 2'd3
    } mon_state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_MULTI    = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_SKIP_Y   = 3'd3;
    localparam logic [2:0] FC_SHORT_Y  = 3'd4;
    localparam logic [2:0] FC_DARK     = 3'd5;

    localparam int APP_EAST  = 0;
    localparam int APP_NORTH = 1;
    localparam int APP_WEST  = 2;
    localparam int APP_SOUTH = 3;

    localparam logic [11:0] LAMPS_RED  = 12'h00F;
    localparam logic [11:0] LAMPS_DARK = 12'h000;

    function automatic colour_t classify(
        input logic g,
        input logic y,
        input logic r
    );
        colour_t c;
        unique case ({g, y, r})
            3'b000:  c = COL_DARK;
            3'b100:  c = COL_G;
            3'b010:  c = COL_Y;
            3'b001:  c = COL_R;
            default: c = COL_MULTI;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tlc_conflict_monitor_tracker.sv
// Per-lamp colour history: previous colour, yellow run and dark run.
// The dark run counter exists only with TLC_MON_DARK_CHECK_EN.
module tlc_lamp_tracker
    import tlc_mon_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int DARK_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic g,
    input  logic y,
    input  logic r,
    input  logic live,
    output logic multi,
    output logic skipped_y,
    output logic short_y,
    output logic dark_over
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] Y_SAT = YW'(MIN_YELLOW);

    colour_t       cur;
    colour_t       prev;
    logic [YW-1:0] ycnt;

    assign cur = classify(g, y, r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= COL_R;
            ycnt <= '0;
        end else begin
            prev <= cur;
            if (cur != COL_Y) begin
                ycnt <= '0;
            end else if (ycnt != Y_SAT) begin
                ycnt <= ycnt + YW'(1);
            end
        end
    end

    assign multi     = (cur == COL_MULTI);
    assign skipped_y = (prev == COL_G) && (cur == COL_R);
    assign short_y   = (prev == COL_Y) && (cur == COL_R) && (ycnt < Y_SAT);

`ifdef TLC_MON_DARK_CHECK_EN
    localparam int DW = $clog2(DARK_LIMIT + 1);
    localparam logic [DW-1:0] D_SAT = DW'(DARK_LIMIT);

    logic [DW-1:0] dcnt;

    // Only dark samples the monitor actually checks extend the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (!live || cur != COL_DARK) begin
            dcnt <= '0;
        end else if (dcnt != D_SAT) begin
            dcnt <= dcnt + DW'(1);
        end
    end

    assign dark_over = live && (cur == COL_DARK) && (dcnt == D_SAT);
`else
    logic unused_live;
    assign unused_live = live;
    assign dark_over   = 1'b0;
`endif

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety stage between the TLC FSM and the lamp drivers; forces flash on faults.
// Optional dark-lamp timeout check: define TLC_MON_DARK_CHECK_EN.
module tlc_conflict_monitor
    import tlc_mon_pkg::*;
#(
    parameter int MIN_YELLOW     = 2,
    parameter int STARTUP_CYCLES = 8,
    parameter int FLASH_HALF     = 4,
    parameter int DARK_LIMIT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] south_in,
    input  logic [11:0] west_in,
    input  logic [11:0] north_in,
    input  logic [11:0] east_in,
    input  logic        fault_clr,
    output logic [11:0] south_lights_gyr,
    output logic [11:0] west_lights_gyr,
    output logic [11:0] north_lights_gyr,
    output logic [11:0] east_lights_gyr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [3:0]  fault_lamp
);

    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [SW-1:0] HOLD_LAST  = SW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FLASH_MID  = FW'(FLASH_HALF);
    localparam logic [47:0]   RED_ALL    = {4{LAMPS_RED}};
    localparam logic [47:0]   DARK_ALL   = {4{LAMPS_DARK}};

    logic [47:0] bus_in;
    logic [15:0] f_multi;
    logic [15:0] f_skip;
    logic [15:0] f_short;
    logic [15:0] f_dark;
    logic [15:0] f_conf;
    logic [15:0] g_low;
    logic [3:0]  app_green;
    logic        conflict;
    logic        live;
    logic        hold_done;
    logic        clr_ok;
    logic        viol;
    logic [2:0]  v_code;
    logic [3:0]  v_lamp;

    mon_state_t    state;
    logic [SW-1:0] hold_cnt;
    logic [FW-1:0] flash_cnt;
    logic [FW-1:0] flash_nxt;
    logic [47:0]   out_q;

    assign bus_in[APP_SOUTH*12 +: 12] = south_in;
    assign bus_in[APP_WEST*12  +: 12] = west_in;
    assign bus_in[APP_NORTH*12 +: 12] = north_in;
    assign bus_in[APP_EAST*12  +: 12] = east_in;

    for (genvar l = 0; l < 16; l++) begin : g_lamp
        localparam int A = l / 4;
        localparam int B = l % 4;

        tlc_lamp_tracker #(
            .MIN_YELLOW (MIN_YELLOW),
            .DARK_LIMIT (DARK_LIMIT)
        ) u_trk (
            .clk       (clk),
            .reset     (reset),
            .g         (bus_in[A*12 + 8 + B]),
            .y         (bus_in[A*12 + 4 + B]),
            .r         (bus_in[A*12 + B]),
            .live      (live),
            .multi     (f_multi[l]),
            .skipped_y (f_skip[l]),
            .short_y   (f_short[l]),
            .dark_over (f_dark[l])
        );

        // Left-turn greens (bit 3) may overlap other approaches.
        if (B < 3) begin : g_thru
            assign g_low[l] = bus_in[A*12 + 8 + B];
        end else begin : g_left
            assign g_low[l] = 1'b0;
        end
    end

    for (genvar a = 0; a < 4; a++) begin : g_app
        assign app_green[a] = |bus_in[a*12 + 8 +: 3];
    end

    assign conflict = (app_green & (app_green - 4'd1)) != 4'd0;
    assign f_conf   = conflict ? g_low : 16'd0;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        viol   = 1'b1;
        v_code = FC_NONE;
        v_lamp = '0;
        if (|f_multi) begin
            v_code = FC_MULTI;
            v_lamp = lowest(f_multi);
        end else if (|f_conf) begin
            v_code = FC_CONFLICT;
            v_lamp = lowest(f_conf);
        end else if (|f_skip) begin
            v_code = FC_SKIP_Y;
            v_lamp = lowest(f_skip);
        end else if (|f_short) begin
            v_code = FC_SHORT_Y;
            v_lamp = lowest(f_short);
        end else if (|f_dark) begin
            v_code = FC_DARK;
            v_lamp = lowest(f_dark);
        end else begin
            viol = 1'b0;
        end
    end

    assign hold_done = (hold_cnt == HOLD_LAST);
    assign clr_ok    = fault_clr && (bus_in == RED_ALL);
    assign flash_nxt = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + FW'(1);

    // The edge leaving an all-red hold forwards, and so checks, its sample.
    assign live = (state == ST_RUN) ||
                  (((state == ST_STARTUP) || (state == ST_RECOVER)) && hold_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_STARTUP;
            hold_cnt   <= '0;
            flash_cnt  <= '0;
            out_q      <= RED_ALL;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_lamp <= '0;
        end else begin
            unique case (state)
                ST_STARTUP, ST_RECOVER: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + SW'(1);
                        out_q    <= RED_ALL;
                    end
                end
                ST_FLASH: begin
                    flash_cnt <= flash_nxt;
                    out_q     <= (flash_nxt < FLASH_MID) ? RED_ALL : DARK_ALL;
                    if (clr_ok) begin
                        state    <= ST_RECOVER;
                        hold_cnt <= '0;
                        out_q    <= RED_ALL;
                    end
                end
                ST_RUN: begin
                end
            endcase

            if (live) begin
                hold_cnt <= '0;
                if (viol) begin
                    state      <= ST_FLASH;
                    flash_cnt  <= '0;
                    out_q      <= RED_ALL;
                    fault      <= 1'b1;
                    fault_code <= v_code;
                    fault_lamp <= v_lamp;
                end else begin
                    state      <= ST_RUN;
                    out_q      <= bus_in;
                    fault      <= 1'b0;
                    fault_code <= FC_NONE;
                    fault_lamp <= '0;
                end
            end
        end
    end

    assign south_lights_gyr = out_q[APP_SOUTH*12 +: 12];
    assign west_lights_gyr  = out_q[APP_WEST*12  +: 12];
    assign north_lights_gyr = out_q[APP_NORTH*12 +: 12];
    assign east_lights_gyr  = out_q[APP_EAST*12  +: 12];

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: directed scenarios plus randomized traffic
// compared every cycle against a rule-level model of the monitor.
module tb_tlc_conflict_monitor;

    localparam int MIN_YELLOW     = 2;
    localparam int STARTUP_CYCLES = 8;
    localparam int FLASH_HALF     = 4;
    localparam int DARK_LIMIT     = 16;

    localparam int C_DARK  = 0;
    localparam int C_G     = 1;
    localparam int C_Y     = 2;
    localparam int C_R     = 3;
    localparam int C_MULTI = 4;

    localparam int M_START = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLASH = 2;
    localparam int M_REC   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fault_clr = 1'b0;
    logic [11:0] south_in = 12'h00F;
    logic [11:0] west_in = 12'h00F;
    logic [11:0] north_in = 12'h00F;
    logic [11:0] east_in = 12'h00F;
    logic [11:0] south_lights_gyr;
    logic [11:0] west_lights_gyr;
    logic [11:0] north_lights_gyr;
    logic [11:0] east_lights_gyr;
    logic        fault;
    logic [2:0]  fault_code;
    logic [3:0]  fault_lamp;

    always #5 clk = ~clk;

    tlc_conflict_monitor #(
        .MIN_YELLOW     (MIN_YELLOW),
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .FLASH_HALF     (FLASH_HALF),
        .DARK_LIMIT     (DARK_LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .south_in         (south_in),
        .west_in          (west_in),
        .north_in         (north_in),
        .east_in          (east_in),
        .fault_clr        (fault_clr),
        .south_lights_gyr (south_lights_gyr),
        .west_lights_gyr  (west_lights_gyr),
        .north_lights_gyr (north_lights_gyr),
        .east_lights_gyr  (east_lights_gyr),
        .fault            (fault),
        .fault_code       (fault_code),
        .fault_lamp       (fault_lamp)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          m_mode;
    int          m_hold;
    int          m_age;
    logic [47:0] m_out;
    logic        m_fault;
    logic [2:0]  m_code;
    logic [3:0]  m_lamp;
    int          prev_col [16];
    int          yrun [16];
    int          drun [16];

    function automatic int colour_of(input logic [47:0] v, input int l);
        int a;
        int b;
        int n;
        a = l / 4;
        b = l % 4;
        n = int'(v[a*12+8+b]) + int'(v[a*12+4+b]) + int'(v[a*12+b]);
        if (n == 0) return C_DARK;
        if (n > 1) return C_MULTI;
        if (v[a*12+8+b]) return C_G;
        if (v[a*12+4+b]) return C_Y;
        return C_R;
    endfunction

    task automatic model_reset();
        m_mode  = M_START;
        m_hold  = 1;
        m_age   = 0;
        m_out   = {4{12'h00F}};
        m_fault = 1'b0;
        m_code  = 3'd0;
        m_lamp  = 4'd0;
        for (int l = 0; l < 16; l++) begin
            prev_col[l] = C_R;
            yrun[l]     = 0;
            drun[l]     = 0;
        end
    endtask

    task automatic model_edge();
        logic [47:0] v;
        int col [16];
        int napp;
        int best_c;
        int best_l;
        bit live;
        bit hit;
        v = {south_in, west_in, north_in, east_in};
        for (int l = 0; l < 16; l++) col[l] = colour_of(v, l);
        napp = 0;
        for (int a = 0; a < 4; a++) if (v[a*12+8 +: 3] != 3'd0) napp++;
        live = (m_mode == M_RUN) ||
               ((m_mode == M_START || m_mode == M_REC) && m_hold == STARTUP_CYCLES);
        best_c = 0;
        best_l = 0;
        for (int c = 5; c >= 1; c--) begin
            for (int l = 15; l >= 0; l--) begin
                hit = 1'b0;
                case (c)
                    1: hit = (col[l] == C_MULTI);
                    2: hit = (napp > 1) && (l % 4 < 3) && v[(l/4)*12 + 8 + l%4];
                    3: hit = (prev_col[l] == C_G) && (col[l] == C_R);
                    4: hit = (prev_col[l] == C_Y) && (col[l] == C_R) &&
                             (yrun[l] < MIN_YELLOW);
`ifdef TLC_MON_DARK_CHECK_EN
                    5: hit = (col[l] == C_DARK) && (drun[l] + 1 > DARK_LIMIT);
`endif
                    default: hit = 1'b0;
                endcase
                if (hit) begin
                    best_c = c;
                    best_l = l;
                end
            end
        end
        if (m_mode == M_FLASH) begin
            m_age++;
            m_out = ((m_age / FLASH_HALF) % 2 == 0) ? {4{12'h00F}} : 48'd0;
            if (fault_clr && v == {4{12'h00F}}) begin
                m_mode = M_REC;
                m_hold = 1;
                m_out  = {4{12'h00F}};
            end
        end else if (!live) begin
            m_hold++;
            m_out = {4{12'h00F}};
        end else if (best_c != 0) begin
            m_mode  = M_FLASH;
            m_age   = 0;
            m_out   = {4{12'h00F}};
            m_fault = 1'b1;
            m_code  = 3'(best_c);
            m_lamp  = 4'(best_l);
        end else begin
            m_mode  = M_RUN;
            m_out   = v;
            m_fault = 1'b0;
            m_code  = 3'd0;
            m_lamp  = 4'd0;
        end
        for (int l = 0; l < 16; l++) begin
            yrun[l]     = (col[l] == C_Y) ? yrun[l] + 1 : 0;
            drun[l]     = (live && col[l] == C_DARK) ? drun[l] + 1 : 0;
            prev_col[l] = col[l];
        end
    endtask

    task automatic cmp_model();
        logic [55:0] act;
        logic [55:0] exp;
        act = {south_lights_gyr, west_lights_gyr, north_lights_gyr,
               east_lights_gyr, fault, fault_code, fault_lamp};
        exp = {m_out, m_fault, m_code, m_lamp};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model cyc=%0d got=%h want=%h", cyc, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        cyc++;
        cmp_model();
    endtask

    task automatic all_red();
        south_in = 12'h00F;
        west_in  = 12'h00F;
        north_in = 12'h00F;
        east_in  = 12'h00F;
    endtask

    task automatic recover();
        all_red();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        repeat (STARTUP_CYCLES) tick();
        chk("recovered", 16'(fault), 16'd0);
    endtask

    logic [11:0] flash_exp [11];
    logic [11:0] a [4];
    int ga;
    int gph;
    int glen;
    int gi;

    initial begin
        flash_exp = '{12'h00F, 12'h00F, 12'h00F, 12'h000, 12'h000, 12'h000,
                      12'h000, 12'h00F, 12'h00F, 12'h00F, 12'h00F};
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        cmp_model();
        chk("rst_east", 16'(east_lights_gyr), 16'h00F);
        chk("rst_fault", 16'(fault), 16'd0);
        chk("rst_code", 16'(fault_code), 16'd0);
        chk("rst_lamp", 16'(fault_lamp), 16'd0);
        for (int i = 0; i < STARTUP_CYCLES - 1; i++) begin
            tick();
            chk("startup_red", 16'(east_lights_gyr), 16'h00F);
        end
        east_in = 12'h10E;
        tick();
        chk("first_fwd", 16'(east_lights_gyr), 16'h10E);
        east_in = 12'h01E;
        tick();
        tick();
        east_in = 12'h00F;
        tick();
        chk("yellow2_ok", 16'(fault), 16'd0);

        south_in = 12'h10E;
        west_in  = 12'h20D;
        tick();
        chk("conf_fault", 16'(fault), 16'd1);
        chk("conf_code", 16'(fault_code), 16'd2);
        chk("conf_lamp", 16'(fault_lamp), 16'd9);
        chk("conf_out", 16'(south_lights_gyr), 16'h00F);
        all_red();
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("flash_seq", 16'(west_lights_gyr), 16'(flash_exp[i]));
        end
        south_in  = 12'h10E;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_ign_fault", 16'(fault), 16'd1);
        chk("clr_ign_code", 16'(fault_code), 16'd2);
        chk("clr_ign_out", 16'(north_lights_gyr), 16'h000);
        all_red();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("acc_fault", 16'(fault), 16'd1);
        for (int i = 0; i < STARTUP_CYCLES - 1; i++) begin
            tick();
            chk("recover_red", 16'(south_lights_gyr), 16'h00F);
        end
        south_in = 12'h10E;
        tick();
        chk("rec_run_fault", 16'(fault), 16'd0);
        chk("rec_run_code", 16'(fault_code), 16'd0);
        chk("rec_run_fwd", 16'(south_lights_gyr), 16'h10E);
        south_in = 12'h01E;
        tick();
        tick();
        south_in = 12'h00F;
        tick();

        east_in = 12'h202;
        tick();
        chk("multi_code", 16'(fault_code), 16'd1);
        chk("multi_lamp", 16'(fault_lamp), 16'd1);
        recover();

        north_in = 12'h40B;
        tick();
        north_in = 12'h00F;
        tick();
        chk("skip_code", 16'(fault_code), 16'd3);
        chk("skip_lamp", 16'(fault_lamp), 16'd6);
        recover();

        south_in = 12'h20D;
        tick();
        south_in = 12'h02D;
        tick();
        south_in = 12'h00F;
        tick();
        chk("short_code", 16'(fault_code), 16'd4);
        chk("short_lamp", 16'(fault_lamp), 16'd13);
        recover();
        south_in = 12'h20D;
        tick();
        south_in = 12'h02D;
        tick();
        tick();
        south_in = 12'h00F;
        tick();
        chk("long_yel_ok", 16'(fault), 16'd0);

        east_in = 12'h202;
        tick();
        chk("pre_rst_fault", 16'(fault), 16'd1);
        east_in = 12'h00F;
        reset = 1'b1;
        #1;
        model_reset();
        cmp_model();
        chk("midrst_fault", 16'(fault), 16'd0);
        chk("midrst_code", 16'(fault_code), 16'd0);
        chk("midrst_out", 16'(east_lights_gyr), 16'h00F);
        tick();
        reset = 1'b0;
        repeat (STARTUP_CYCLES) tick();

        east_in = 12'h00E;
        repeat (DARK_LIMIT) tick();
        chk("dark16", 16'(fault), 16'd0);
        tick();
`ifdef TLC_MON_DARK_CHECK_EN
        chk("dark_fault", 16'(fault), 16'd1);
        chk("dark_code", 16'(fault_code), 16'd5);
        chk("dark_lamp", 16'(fault_lamp), 16'd0);
`else
        chk("dark_legal", 16'(fault), 16'd0);
        chk("dark_code", 16'(fault_code), 16'd0);
`endif
        recover();

        ga   = 0;
        gph  = 2;
        glen = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) a[k] = 12'h00F;
            if (gph == 0) a[ga] = 12'h10E;
            else if (gph == 1) a[ga] = 12'h01E;
            glen--;
            if (glen <= 0) begin
                if (gph == 0) begin
                    glen = int'($urandom_range(0, 3));
                    gph  = (glen == 0) ? 2 : 1;
                    if (gph == 2) glen = 1;
                end else if (gph == 1) begin
                    gph  = 2;
                    glen = 1;
                end else begin
                    gph  = 0;
                    ga   = (ga + 1) % 4;
                    glen = int'($urandom_range(2, 5));
                end
            end
            if ($urandom_range(0, 99) < 4) begin
                gi    = int'($urandom_range(0, 3));
                a[gi] = 12'($urandom());
            end
            if (m_mode == M_FLASH) begin
                if ($urandom_range(0, 9) < 7) begin
                    for (int k = 0; k < 4; k++) a[k] = 12'h00F;
                end
                fault_clr = ($urandom_range(0, 3) == 0);
            end else begin
                fault_clr = ($urandom_range(0, 29) == 0);
            end
            south_in = a[3];
            west_in  = a[2];
            north_in = a[1];
            east_in  = a[0];
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                cmp_model();
                tick();
                reset = 1'b0;
            end
            tick();
        end
        fault_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlc_conflict_monitor.md
# tlc_conflict_monitor

Safety stage directly downstream of the traffic-light controller FSM: consumes the four 12-bit `{green[3:0],yellow[3:0],red[3:0]}` approach buses and drives the lamp outputs. In normal operation it forwards the buses with one cycle of latency. It checks every sample for illegal lamp patterns and illegal lamp transitions. On the first violation it latches a fault code and forces all approaches to flashing red until an operator-cleared recovery completes.

## Interface
- `MIN_YELLOW`, 2: minimum consecutive yellow cycles before a lamp may turn red.
- `STARTUP_CYCLES`, 8: solid all-red cycles after reset and during recovery.
- `FLASH_HALF`, 4: cycles per flash half-period.
- `DARK_LIMIT`, 16: maximum consecutive dark cycles per lamp. Used only with the configuration macro.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `south_in`, `west_in`, `north_in`, `east_in` in 12 each: `{g[3:0],y[3:0],r[3:0]}` from the controller.
- `fault_clr` in 1: single-cycle request to leave flash.
- `south_lights_gyr`, `west_lights_gyr`, `north_lights_gyr`, `east_lights_gyr` out 12 each: lamp drive, same packing as the inputs.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: 0 none, 1 multi-colour, 2 conflict, 3 skipped yellow, 4 short yellow, 5 dark.
- `fault_lamp` out 4: offending lamp index, computed as approach*4 + bit. Approach encoding: south=3, west=2, north=1, east=0.

## Operation
- Each lamp's colour is classified every cycle as DARK, G, Y, R or MULTI (more than one colour bit set).
- 16 lamp histories are updated every cycle in all states:
  - previous colour: reset value R;
  - yellow run counter: counts sampled Y cycles, saturates at MIN_YELLOW, clears on any non-Y sample;
  - dark run counter (macro only).
- Checks act only in RUN:
  - code 1: any lamp MULTI.
  - code 2: green in bits [2:0] set in more than one approach. Bit 3 (left-turn) greens never conflict.
  - code 3: lamp previously G, now R.
  - code 4: lamp previously Y, now R, with yellow count < MIN_YELLOW. Y→G and Y→DARK are legal.
  - code 5: see Configuration.
- Simultaneous violations are resolved in two steps:
  - the lowest code wins;
  - within that code, the lowest lamp index wins. For code 2, the reported lamp is the lowest-index conflicting green bit.
- States:
  - STARTUP: outputs all red. After STARTUP_CYCLES → RUN.
  - RUN: outputs = previous-cycle inputs. Violation → FLASH, setting `fault=1` and loading code and lamp.
  - FLASH: phase counter alternates FLASH_HALF cycles all-red `12'h00F` with FLASH_HALF cycles all-dark `12'h000`, starting with the red phase. `fault_clr` is accepted only when all inputs are all-red that cycle (`12'h00F` each); acceptance → RECOVER. Otherwise `fault_clr` is ignored.
  - RECOVER: outputs solid all-red for STARTUP_CYCLES, then → RUN, clearing `fault`, `fault_code` and `fault_lamp`.
- Fault fields hold their values until the RECOVER→RUN transition. They are never overwritten while in FLASH.

## Timing
- Reset values:
  - state STARTUP, all lamp outputs `12'h00F`;
  - `fault=0`, `fault_code=0`, `fault_lamp=0`;
  - lamp histories: R, counters 0.
- Pass-through latency in RUN: 1 cycle.
- Detection:
  - an offending input sampled at edge N sets `fault` at edge N;
  - the output register loads the flash-red pattern at that same edge;
  - the offending pattern never reaches the outputs.
- The STARTUP→RUN transition happens at the edge after STARTUP_CYCLES all-red output cycles. The first forwarded sample is the one taken at that edge.
- Reset asserted mid-FLASH or mid-RECOVER: immediate return to reset values, fault cleared.

## Configuration
- `TLC_MON_DARK_CHECK_EN` defined:
  - per-lamp saturating dark counters are instantiated;
  - a lamp that is DARK for more than DARK_LIMIT consecutive RUN cycles raises code 5.
- Undefined: no dark counters are built, DARK is legal indefinitely, and code 5 is never produced.

## Structure
- Package `tlc_mon_pkg` holds:
  - colour encoding (DARK/G/Y/R/MULTI);
  - fault-code constants;
  - the monitor state enum;
  - approach index constants.
- Sub-module `tlc_lamp_tracker`, instantiated 16 times:
  - owns the previous colour, yellow counter and (macro-gated) dark counter;
  - emits per-lamp multi, skipped-yellow, short-yellow and dark flags.
- The top level owns the conflict check, priority encoder, state machine, flash counter and output registers.

## Test plan
- Reset release, all inputs `12'h00F`: outputs `12'h00F` for 8 cycles. Then east_in=`12'h10E` appears on `east_lights_gyr` one cycle after it is applied.
- Conflict: south_in green `4'h1` and west_in green `4'h2` in the same cycle → `fault=1`, code 2, lamp 9 (west bit 1). Outputs then show `12'h00F` ×4, `12'h000` ×4, repeating.
- Multi-colour: east_in=`12'h202`, i.e. bit 1 both green and red → code 1, lamp 1. North bit 2 G then R on the next cycle → code 3, lamp 6.
- Short yellow: south bit 1 sequence G, Y (1 cycle), R with MIN_YELLOW=2 → code 4, lamp 13. The same sequence with Y held 2 cycles → no fault.
- Recovery:
  - `fault_clr` while south_in=`12'h10E` is ignored and the flash continues;
  - `fault_clr` with all inputs `12'h00F` → 8 cycles of solid red, then RUN with `fault=0` and `fault_code=0`.
- With `TLC_MON_DARK_CHECK_EN`: east bit 0 dark for 17 RUN cycles → code 5, lamp 0. Without the macro the same stimulus raises no fault.
